mem_arbiter: RTL

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter_pkg.sv | 19 +
 rtl/mem_arbiter_starve_counter.sv | 29 ++
 rtl/mem_arbiter.sv | 108 ++++++++++
 3 files changed

// File: rtl/mem_arbiter_pkg.sv
// Shared definitions for the instruction/data memory arbiter.
package mem_arbiter_pkg;

  localparam int unsigned DEF_WORD_SIZE  = 32;
  localparam int unsigned DEF_ADDR_WIDTH = 32;

  // Port identifier recorded for each outstanding read.
  typedef enum logic {
    PORT_IF = 1'b0,
    PORT_D  = 1'b1
  } port_e;

  // Outstanding-read owner: which port gets next cycle's m_rdata.
  typedef struct packed {
    logic  valid;
    port_e port;
  } owner_t;

endpackage : mem_arbiter_pkg

// File: rtl/mem_arbiter_starve_counter.sv
// Saturating counter with clear; flags when the count has reached its limit.
module starve_counter #(
  parameter int unsigned LIMIT = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic inc,
  input  logic clr,
  output logic at_limit
);

  localparam int unsigned CW = (LIMIT < 1) ? 1 : $clog2(LIMIT + 1);

  logic [CW-1:0] count;

  assign at_limit = (count == CW'(LIMIT));

  // Clear has priority over increment; increment stops at the limit.
  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (inc && !at_limit) begin
      count <= count + CW'(1);
    end
  end

endmodule : starve_counter

// File: rtl/mem_arbiter.sv
// Two-port (fetch/data) arbiter onto a single-ported memory with 1-cycle read latency.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int unsigned WORD_SIZE    = DEF_WORD_SIZE,
  parameter int unsigned ADDR_WIDTH   = DEF_ADDR_WIDTH,
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  if_req,
  input  logic [ADDR_WIDTH-1:0] if_addr,
  output logic                  if_gnt,
  output logic                  if_rvalid,
  output logic [WORD_SIZE-1:0]  if_rdata,
  input  logic                  d_req,
  input  logic                  d_we,
  input  logic [ADDR_WIDTH-1:0] d_addr,
  input  logic [WORD_SIZE-1:0]  d_wdata,
  output logic                  d_gnt,
  output logic                  d_rvalid,
  output logic [WORD_SIZE-1:0]  d_rdata,
  output logic                  m_en,
  output logic                  m_we,
  output logic [ADDR_WIDTH-1:0] m_addr,
  output logic [WORD_SIZE-1:0]  m_wdata,
  input  logic [WORD_SIZE-1:0]  m_rdata
);

  logic                 starved;
  owner_t               owner_q;
  logic [WORD_SIZE-1:0] if_rdata_q;
  logic [WORD_SIZE-1:0] d_rdata_q;

  // Counts cycles the fetch port has been waiting while requesting.
  starve_counter #(
    .LIMIT (STARVE_LIMIT)
  ) u_starve (
    .clk      (clk),
    .rst      (rst),
    .inc      (if_req & ~if_gnt),
    .clr      (if_gnt | ~if_req),
    .at_limit (starved)
  );

  // Same-cycle grant: data wins by default, fetch wins once starved.
  always_comb begin
    if_gnt = 1'b0;
    d_gnt  = 1'b0;
    if (!rst) begin
      if (if_req && d_req) begin
        if (starved) if_gnt = 1'b1;
        else         d_gnt  = 1'b1;
      end else if (if_req) begin
        if_gnt = 1'b1;
      end else if (d_req) begin
        d_gnt = 1'b1;
      end
    end
  end

  // Steer the winner's request onto the shared memory port.
  always_comb begin
    m_en    = if_gnt | d_gnt;
    m_we    = d_gnt & d_we;
    m_addr  = '0;
    m_wdata = '0;
    if (d_gnt) begin
      m_addr  = d_addr;
      m_wdata = d_wdata;
    end else if (if_gnt) begin
      m_addr = if_addr;
    end
  end

  // Remember who owns the read data returning next cycle; writes leave no owner.
  always_ff @(posedge clk) begin
    if (rst) begin
      owner_q <= '0;
    end else if (if_gnt) begin
      owner_q <= '{valid: 1'b1, port: PORT_IF};
    end else if (d_gnt && !d_we) begin
      owner_q <= '{valid: 1'b1, port: PORT_D};
    end else begin
      owner_q <= '0;
    end
  end

  // Returned data is qualified by the owner; reset suppresses a pending return.
  always_comb begin
    if_rvalid = !rst && owner_q.valid && (owner_q.port == PORT_IF);
    d_rvalid  = !rst && owner_q.valid && (owner_q.port == PORT_D);
    if_rdata  = rst ? '0 : (if_rvalid ? m_rdata : if_rdata_q);
    d_rdata   = rst ? '0 : (d_rvalid  ? m_rdata : d_rdata_q);
  end

  // Hold the last routed word on each port between returns.
  always_ff @(posedge clk) begin
    if (rst) begin
      if_rdata_q <= '0;
      d_rdata_q  <= '0;
    end else begin
      if (if_rvalid) if_rdata_q <= m_rdata;
      if (d_rvalid)  d_rdata_q  <= m_rdata;
    end
  end

endmodule : mem_arbiter
